bcd_score_keeper: RTL and testbench
===================================

# bcd_score_keeper

Runtime score and high-score tracker for the dinosaur game. Sits between the game logic (consumes its game-over state as `running`) and the 4-digit seven-segment driver (feeds its 16-bit `num` input). It counts points in packed BCD at a fixed tick rate while a game is running, freezes on game over, latches a session high score, and selects which value is shown.

## Interface

Parameters:
- `TICK_DIV`, default 5_000_000: clk cycles per score point (20 points/s at 100 MHz); legal range 1 .. 2^26.

Ports:
- `clk`  in  1  system clock.
- `RST`  in  1  synchronous, active-high reset.
- `clear`  in  1  new-game request (level); zeroes the current score.
- `running`  in  1  game in progress (top level drives `!game_over`).
- `show_hi`  in  1  1 = display the high score, 0 = display the current score.
- `score`  out  16  current score, 4 packed BCD digits [15:12]=thousands.
- `hi_score`  out  16  session high score, packed BCD.
- `disp`  out  16  registered display value for the seven-segment driver.
- `new_hi`  out  1  the last finished game set a new high score.
- `tick`  out  1  one-cycle pulse, high on the cycle the score increments.

## Operation

- Prescaler `pcnt`, 26 bits, counts 0..TICK_DIV-1 while `running && !clear`; holds while `!running`; reset to 0 by `clear` or `RST`.
- When `pcnt == TICK_DIV-1` and counting: `pcnt` wraps to 0 and `score` increments by 1 in BCD; `tick` is registered high for that cycle.
- BCD increment: a digit at 9 becomes 0 and carries into the next digit. At 9999 the score saturates: `score` holds, `pcnt` keeps wrapping, and `tick` stays 0.
- `clear` (priority over counting): `score <= 0`, `pcnt <= 0`, `new_hi <= 0`. `hi_score` is never modified by `clear`.
- Game-over detect: `run_q` registers `running`. `fall = run_q & ~running`.
- On `fall`: if `score > hi_score`, then `hi_score <= score` and `new_hi <= 1`; otherwise both hold. The comparison is unsigned on the 16-bit packed value, which is valid because BCD ordering equals binary ordering.
- Simultaneous `fall` and `clear`: the high-score compare uses the pre-clear `score` (register value), so the update still happens. `score` clears. `new_hi` takes the compare result, because the `fall` update has priority over the `clear` zeroing of `new_hi`.
- `disp <= show_hi ? hi_score : score`, using the register values of the current cycle.
- Rising edge of `running`: no action other than counting resuming.

## Timing

- Reset values: `score`=0, `hi_score`=0, `disp`=0, `new_hi`=0, `tick`=0, `pcnt`=0, `run_q`=0. Because `run_q` resets to 0, no false `fall` occurs after reset.
- First increment: TICK_DIV cycles after the first edge where `running=1` and `clear=0` are sampled. The score change and `tick` are visible after the same edge.
- `hi_score`/`new_hi` update on the first edge where `running=0` is sampled after `running=1`. That is 1 cycle of latency from the input change.
- `disp` lags `score`/`hi_score`/`show_hi` by 1 cycle (2 cycles from the `fall` input to `disp` when `show_hi=1`).
- A prescaler count is never lost or doubled across pause/resume: the count continues from the held `pcnt`.
- `RST` mid-game returns all state to reset values on the next edge, including `hi_score`.

## Test plan

Use `TICK_DIV`=4 unless noted.

- `RST` pulse with arbitrary inputs -> every output 0 on the following cycle; hold `running=0` for 10 cycles -> `new_hi` stays 0 and `hi_score` stays 0.
- `clear` 1 cycle, then `running=1` for 40 cycles -> `score`=16'h0010, exactly 10 `tick` pulses, spaced 4 cycles apart.
- `TICK_DIV`=1, run 99 cycles -> 16'h0099, next cycle 16'h0100. Run 10 050 cycles -> `score` holds 16'h9999 and `tick`=0 after saturation.
- Game at 16'h0123 ends (`running` 1->0) with `hi_score`=16'h0050 -> one cycle later `hi_score`=16'h0123 and `new_hi`=1. `clear`, then a game ending at 16'h0100 -> `hi_score` stays 16'h0123 and `new_hi`=0.
- `running` falls on the same edge `clear` rises with `score`=16'h0200 > `hi_score` -> `hi_score`=16'h0200, `new_hi`=1, `score`=0.
- Pause mid-count: `running` low for 7 cycles with `pcnt`=2 -> the next increment occurs 2 cycles after resume. Toggle `show_hi` -> `disp` switches between `score` and `hi_score` exactly 1 cycle later.

Source files
------------

// File: rtl/bcd_score_keeper.sv
// Score and session high-score tracker for the dinosaur game: packed-BCD point
// counter driven by a prescaler, game-over high-score latch and display select.
module bcd_score_keeper #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        clear,
    input  logic        running,
    input  logic        show_hi,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic [15:0] disp,
    output logic        new_hi,
    output logic        tick
);

    localparam logic [25:0] PCNT_MAX = 26'(TICK_DIV - 1);

    logic [25:0] pcnt_reg, pcnt_next;
    logic [15:0] score_reg, score_next;
    logic [15:0] hi_reg, hi_next;
    logic [15:0] disp_reg, disp_next;
    logic        new_hi_reg, new_hi_next;
    logic        tick_reg, tick_next;
    logic        run_q_reg;

    logic [15:0] score_inc;
    logic [4:0]  carry;
    logic        saturated;
    logic        fall;

    // Ripple BCD increment; a carry out of the top digit means the score is 9999.
    assign carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = score_reg[gi*4 +: 4];
            assign score_inc[gi*4 +: 4] = !carry[gi]     ? digit :
                                          (digit == 4'd9) ? 4'd0  : digit + 4'd1;
            assign carry[gi+1] = carry[gi] & (digit == 4'd9);
        end
    endgenerate

    assign saturated = carry[4];
    assign fall      = run_q_reg & ~running;

    always_comb begin
        pcnt_next   = pcnt_reg;
        score_next  = score_reg;
        hi_next     = hi_reg;
        new_hi_next = new_hi_reg;
        tick_next   = 1'b0;
        disp_next   = show_hi ? hi_reg : score_reg;

        if (clear) begin
            score_next  = 16'h0000;
            pcnt_next   = 26'd0;
            new_hi_next = 1'b0;
        end else if (running) begin
            if (pcnt_reg == PCNT_MAX) begin
                pcnt_next = 26'd0;
                if (!saturated) begin
                    score_next = score_inc;
                    tick_next  = 1'b1;
                end
            end else begin
                pcnt_next = pcnt_reg + 26'd1;
            end
        end

        // Compares the pre-clear score and overrides the clear of new_hi.
        if (fall && (score_reg > hi_reg)) begin
            hi_next     = score_reg;
            new_hi_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pcnt_reg   <= 26'd0;
            score_reg  <= 16'h0000;
            hi_reg     <= 16'h0000;
            disp_reg   <= 16'h0000;
            new_hi_reg <= 1'b0;
            tick_reg   <= 1'b0;
            run_q_reg  <= 1'b0;
        end else begin
            pcnt_reg   <= pcnt_next;
            score_reg  <= score_next;
            hi_reg     <= hi_next;
            disp_reg   <= disp_next;
            new_hi_reg <= new_hi_next;
            tick_reg   <= tick_next;
            run_q_reg  <= running;
        end
    end

    assign score    = score_reg;
    assign hi_score = hi_reg;
    assign disp     = disp_reg;
    assign new_hi   = new_hi_reg;
    assign tick     = tick_reg;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Bench for bcd_score_keeper: two instances (TICK_DIV 4 and 1) share stimulus;
// a decimal-integer reference model feeds a per-cycle scoreboard.
module tb_bcd_score_keeper;

    logic        clk;
    logic        rst, clr, running, show_hi;
    logic [15:0] score4, hi4, disp4, score1, hi1, disp1;
    logic        new_hi4, tick4, new_hi1, tick1;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [15:0] score;
        logic [15:0] hi;
        logic [15:0] disp;
        logic        new_hi;
        logic        tick;
    } obs_t;

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    // Reference model state, in plain decimal integers.
    int       div_k[2] = '{4, 1};
    int       m_score[2], m_pcnt[2], m_hi[2];
    bit       m_new[2], m_tick[2], m_runq[2];
    int       m_disp[2];

    bcd_score_keeper #(.TICK_DIV(4)) u4 (
        .clk(clk), .RST(rst), .clear(clr), .running(running), .show_hi(show_hi),
        .score(score4), .hi_score(hi4), .disp(disp4), .new_hi(new_hi4), .tick(tick4)
    );

    bcd_score_keeper #(.TICK_DIV(1)) u1 (
        .clk(clk), .RST(rst), .clear(clr), .running(running), .show_hi(show_hi),
        .score(score1), .hi_score(hi1), .disp(disp1), .new_hi(new_hi1), .tick(tick1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_step(input bit r, input bit c, input bit run, input bit sh);
        obs_t e[2];
        for (int k = 0; k < 2; k++) begin
            int  s0;
            int  h0;
            bit  fall;
            s0   = m_score[k];
            h0   = m_hi[k];
            fall = m_runq[k] && !run;
            if (r) begin
                m_score[k] = 0; m_pcnt[k] = 0; m_hi[k] = 0; m_disp[k] = 0;
                m_new[k] = 0; m_tick[k] = 0; m_runq[k] = 0;
            end else begin
                m_disp[k] = sh ? h0 : s0;
                m_tick[k] = 0;
                if (c) begin
                    m_score[k] = 0; m_pcnt[k] = 0; m_new[k] = 0;
                end else if (run) begin
                    if (m_pcnt[k] == div_k[k] - 1) begin
                        m_pcnt[k] = 0;
                        if (s0 < 9999) begin
                            m_score[k] = s0 + 1;
                            m_tick[k]  = 1;
                        end
                    end else begin
                        m_pcnt[k] = m_pcnt[k] + 1;
                    end
                end
                if (fall && s0 > h0) begin
                    m_hi[k]  = s0;
                    m_new[k] = 1;
                end
                m_runq[k] = run;
            end
            e[k] = '{score: to_bcd(m_score[k]), hi: to_bcd(m_hi[k]),
                     disp: to_bcd(m_disp[k]), new_hi: m_new[k], tick: m_tick[k]};
        end
        exp_q0.push_back(e[0]);
        exp_q1.push_back(e[1]);
    endtask

    // Called at a negedge; returns at the next negedge, after the DUT edge.
    task automatic step(input bit r, input bit c, input bit run, input bit sh);
        rst = r; clr = c; running = run; show_hi = sh;
        model_step(r, c, run, sh);
        @(negedge clk);
    endtask

    task automatic run_n(input int n, input bit run);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, run, 1'b0);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare just after each edge.
    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                a = '{score: score4, hi: hi4, disp: disp4, new_hi: new_hi4, tick: tick4};
                n_checks++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outs_div4 t=%0t: got sc=%h hi=%h disp=%h nh=%b tk=%b expected sc=%h hi=%h disp=%h nh=%b tk=%b",
                             $time, a.score, a.hi, a.disp, a.new_hi, a.tick,
                             e.score, e.hi, e.disp, e.new_hi, e.tick);
                end
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                a = '{score: score1, hi: hi1, disp: disp1, new_hi: new_hi1, tick: tick1};
                n_checks++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outs_div1 t=%0t: got sc=%h hi=%h disp=%h nh=%b tk=%b expected sc=%h hi=%h disp=%h nh=%b tk=%b",
                             $time, a.score, a.hi, a.disp, a.new_hi, a.tick,
                             e.score, e.hi, e.disp, e.new_hi, e.tick);
                end
            end
        end
    end

    initial begin
        int ticks;
        int last_tick;
        bit r_run;
        bit r_sh;
        rst = 1'b1; clr = 1'b0; running = 1'b0; show_hi = 1'b0;
        @(negedge clk);

        // Reset with arbitrary other inputs.
        step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        step(1'b1, 1'($urandom), 1'b1, 1'($urandom));
        check("rst_score", score4, 16'h0000);
        check("rst_hi", hi4, 16'h0000);
        check("rst_disp", disp4, 16'h0000);
        check("rst_new_hi", 16'(new_hi4), 16'h0000);
        check("rst_tick", 16'(tick4), 16'h0000);
        run_n(10, 1'b0);
        check("idle_new_hi", 16'(new_hi4), 16'h0000);
        check("idle_hi", hi4, 16'h0000);

        // 40 running cycles at TICK_DIV=4: ten ticks, four cycles apart.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks = 0;
        last_tick = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (tick4) begin
                if (last_tick >= 0) check("tick_spacing", 16'(i - last_tick), 16'd4);
                last_tick = i;
                ticks++;
            end
        end
        check("score_40", score4, 16'h0010);
        check("tick_count", 16'(ticks), 16'd10);
        check("score_40_div1", score1, 16'h0040);

        // Game ends with the first high score, then a run reaching 0050.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("first_hi", hi4, 16'h0010);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_n(99, 1'b1);
        check("div1_0099", score1, 16'h0099);
        run_n(1, 1'b1);
        check("div1_0100", score1, 16'h0100);
        run_n(100, 1'b1);
        check("score_0050", score4, 16'h0050);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("hi_0050", hi4, 16'h0050);

        // Game ending at 0123 beats 0050.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_n(492, 1'b1);
        check("score_0123", score4, 16'h0123);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("hi_0123", hi4, 16'h0123);
        check("new_hi_set", 16'(new_hi4), 16'h0001);

        // Game ending at 0100 does not beat 0123.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("new_hi_cleared", 16'(new_hi4), 16'h0000);
        run_n(400, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("hi_kept", hi4, 16'h0123);
        check("new_hi_low", 16'(new_hi4), 16'h0000);

        // Fall coincident with clear at 0200.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_n(800, 1'b1);
        check("score_0200", score4, 16'h0200);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("fallclr_hi", hi4, 16'h0200);
        check("fallclr_new_hi", 16'(new_hi4), 16'h0001);
        check("fallclr_score", score4, 16'h0000);

        // Pause with the prescaler at 2; resume needs two more cycles.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_n(6, 1'b1);
        run_n(7, 1'b0);
        check("pause_hold", score4, 16'h0001);
        run_n(1, 1'b1);
        check("resume_1", score4, 16'h0001);
        run_n(1, 1'b1);
        check("resume_2", score4, 16'h0002);
        check("resume_tick", 16'(tick4), 16'h0001);

        // Display select follows show_hi one cycle later.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("disp_hi", disp4, 16'h0200);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("disp_score", disp4, 16'h0002);

        // Saturation at 9999 with TICK_DIV=1.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_n(10050, 1'b1);
        check("sat_score", score1, 16'h9999);
        check("sat_tick", 16'(tick1), 16'h0000);

        // Randomised traffic.
        r_run = 1'b1;
        r_sh  = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) r_run = ~r_run;
            if ($urandom_range(0, 7) == 0)  r_sh  = ~r_sh;
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 79) == 0), r_run, r_sh);
        end

        // Reset mid-game clears everything including the high score.
        run_n(20, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("midrst_hi", hi4, 16'h0000);
        check("midrst_score", score1, 16'h0000);

        for (int i = 0; i < 5; i++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
            @(negedge clk);
        end
        n_checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q0.size() + exp_q1.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
